rgb_pixel_colorizer: RTL

//   Next-generation character colour stage of the PS/2-to-VGA text path. Turns the

---
 rtl/rgb_pixel_colorizer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rgb_pixel_colorizer.sv
// Character colour stage: turns the serialised glyph bit into R/G/B codes with
// keyboard-selected colour, a free-running blink generator and PWM brightness dimming.
module rgb_pixel_colorizer #(
    parameter int CW       = 3,
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 10,
    parameter int PWM_BITS = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          display_area,
    input  logic          pixel_on,
    input  logic          cmd_valid,
    input  logic [2:0]    cmd,
    output logic [CW-1:0] R,
    output logic [CW-1:0] G,
    output logic [CW-1:0] B,
    output logic          blink_phase
);

    localparam int DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int BCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BCW-1:0]      BLINK_LAST = BCW'(DIV - 1);
    localparam logic [PWM_BITS-1:0] LMAX       = '1;

    typedef enum logic [1:0] {
        COL_WHITE = 2'd0,
        COL_RED   = 2'd1,
        COL_GREEN = 2'd2,
        COL_BLUE  = 2'd3
    } colour_t;

    typedef enum logic [2:0] {
        CMD_WHITE     = 3'd0,
        CMD_RED       = 3'd1,
        CMD_GREEN     = 3'd2,
        CMD_BLUE      = 3'd3,
        CMD_BLINK     = 3'd4,
        CMD_BRIGHT_UP = 3'd5,
        CMD_BRIGHT_DN = 3'd6,
        CMD_DEFAULT   = 3'd7
    } cmd_t;

    colour_t             colour_q, colour_d;
    logic                blink_en_q, blink_en_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [BCW-1:0]      blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [CW-1:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic                pwm_on, show;

    always_comb begin
        colour_d      = colour_q;
        blink_en_d    = blink_en_q;
        level_d       = level_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        pwm_cnt_d     = pwm_cnt_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;

        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        // Enabling blink restarts the generator so the first half-period is always visible.
        if (cmd_valid) begin
            case (cmd_t'(cmd))
                CMD_WHITE:     colour_d = COL_WHITE;
                CMD_RED:       colour_d = COL_RED;
                CMD_GREEN:     colour_d = COL_GREEN;
                CMD_BLUE:      colour_d = COL_BLUE;
                CMD_BLINK: begin
                    blink_en_d = ~blink_en_q;
                    if (!blink_en_q) begin
                        blink_cnt_d   = '0;
                        blink_phase_d = 1'b1;
                    end
                end
                CMD_BRIGHT_UP: if (level_q != LMAX) level_d = level_q + 1'b1;
                CMD_BRIGHT_DN: if (level_q != '0)   level_d = level_q - 1'b1;
                CMD_DEFAULT: begin
                    colour_d   = COL_WHITE;
                    blink_en_d = 1'b0;
                    level_d    = LMAX;
                end
            endcase
        end

        pwm_on = (level_q == LMAX) || (pwm_cnt_q < level_q);
        show   = display_area && pixel_on && pwm_on && (!blink_en_q || blink_phase_q);

        // The pixel is built from pre-command state, so a colliding command lands on the next pixel.
        if (pix_en) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            r_d = (show && (colour_q == COL_WHITE || colour_q == COL_RED))   ? '1 : '0;
            g_d = (show && (colour_q == COL_WHITE || colour_q == COL_GREEN)) ? '1 : '0;
            b_d = (show && (colour_q == COL_WHITE || colour_q == COL_BLUE))  ? '1 : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colour_q      <= COL_WHITE;
            blink_en_q    <= 1'b0;
            level_q       <= LMAX;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            pwm_cnt_q     <= '0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            colour_q      <= colour_d;
            blink_en_q    <= blink_en_d;
            level_q       <= level_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pwm_cnt_q     <= pwm_cnt_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
        end
    end

    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;
    assign blink_phase = blink_phase_q;

endmodule
